video_frame_source: RTL and testbench



---
 rtl/video_frame_source_if.sv | 26 ++
 rtl/video_frame_source.sv | 101 ++++++++++
 tb/tb_video_frame_source.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/video_frame_source_if.sv
// video_frame_source_if: frame timing, dual-frame pixel data and target status from the synthetic source
interface video_frame_source_if;
    logic        per_frame_vsync;
    logic        per_frame_href;
    logic        per_frame_clken;
    logic [23:0] pix_data_in_A;
    logic [23:0] pix_data_in_B;
    logic [7:0]  per_img_red;
    logic [7:0]  per_img_green;
    logic [7:0]  per_img_blue;
    logic [9:0]  target_x;
    logic [15:0] frame_cnt;
    logic        frame_done;
    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken,
        output pix_data_in_A, pix_data_in_B,
        output per_img_red, per_img_green, per_img_blue,
        output target_x, frame_cnt, frame_done
    );
    modport slave (
        input per_frame_vsync, per_frame_href, per_frame_clken,
        input pix_data_in_A, pix_data_in_B,
        input per_img_red, per_img_green, per_img_blue,
        input target_x, frame_cnt, frame_done
    );
endinterface

// File: rtl/video_frame_source.sv
// video_frame_source: raster timing plus a bouncing white box rendered into current/previous RGB frames
module video_frame_source #(
    parameter logic [9:0] IMG_HDISP = 10'd640,
    parameter logic [9:0] IMG_VDISP = 10'd480,
    parameter logic [9:0] H_BLANK   = 10'd160,
    parameter logic [9:0] V_BLANK   = 10'd45,
    parameter logic [3:0] PIX_DIV   = 4'd1,
    parameter logic [9:0] BOX_W     = 10'd32,
    parameter logic [9:0] BOX_H     = 10'd32,
    parameter logic [9:0] BOX_Y     = 10'd200,
    parameter logic [9:0] STEP      = 10'd8
) (
    input logic sys_clk,
    input logic sys_rst,
    input logic run,
    video_frame_source_if.master vid
);
    localparam logic [10:0] HD = {1'b0, IMG_HDISP};
    localparam logic [10:0] VD = {1'b0, IMG_VDISP};
    localparam logic [10:0] HT = HD + {1'b0, H_BLANK};
    localparam logic [10:0] VT = VD + {1'b0, V_BLANK};
    localparam logic [10:0] BW = {1'b0, BOX_W};
    localparam logic [10:0] BH = {1'b0, BOX_H};
    localparam logic [10:0] BY = {1'b0, BOX_Y};
    localparam logic [10:0] ST = {1'b0, STEP};
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nx;
    logic [3:0] div;
    logic [10:0] hcnt, vcnt, cx, px;
    logic [9:0] cur_x, prev_x;
    logic dir_left, turn, go_left;
    logic [15:0] frame_cnt;
    logic tick, h_last, fb, vsync, href, rows, in_a, in_b;
    logic vsync_q, href_q, clken_q, done_q;
    logic [23:0] a_q, b_q;
    always_ff @(posedge sys_clk)
        if (sys_rst) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        cx = {1'b0, cur_x};
        px = {1'b0, prev_x};
        tick = state == ACTIVE && div == 4'd0;
        h_last = hcnt == HT - 11'd1;
        fb = tick && h_last && vcnt == VT - 11'd1;
        vsync = state == ACTIVE && vcnt < VD;
        href = vsync && hcnt < HD;
        rows = vcnt >= BY && vcnt < BY + BH;
        in_a = rows && hcnt >= cx && hcnt < cx + BW;
        in_b = rows && hcnt >= px && hcnt < px + BW;
        // direction after this boundary's decision: flip when the next step would leave the line
        turn = dir_left ? cx < ST : cx + ST + BW > HD;
        go_left = dir_left ^ turn;
        state_nx = state == IDLE ? (run ? ACTIVE : IDLE) : (fb && !run ? IDLE : ACTIVE);
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div <= '0;
            hcnt <= '0;
            vcnt <= '0;
            cur_x <= '0;
            prev_x <= '0;
            dir_left <= 1'b0;
            frame_cnt <= '0;
            vsync_q <= 1'b0;
            href_q <= 1'b0;
            clken_q <= 1'b0;
            done_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            div <= (state == IDLE || div == PIX_DIV - 4'd1) ? 4'd0 : div + 4'd1;
            if (tick) begin
                hcnt <= h_last ? 11'd0 : hcnt + 11'd1;
                if (h_last) vcnt <= vcnt == VT - 11'd1 ? 11'd0 : vcnt + 11'd1;
            end
            if (fb) begin
                prev_x <= cur_x;
                dir_left <= go_left;
                cur_x <= go_left ? cur_x - STEP : cur_x + STEP;
                frame_cnt <= frame_cnt + 16'd1;
            end
            vsync_q <= vsync;
            href_q <= href;
            clken_q <= href && tick;
            done_q <= fb;
            a_q <= {24{href && in_a}};
            b_q <= {24{href && in_b}};
        end
    end
    assign vid.per_frame_vsync = vsync_q;
    assign vid.per_frame_href = href_q;
    assign vid.per_frame_clken = clken_q;
    assign vid.pix_data_in_A = a_q;
    assign vid.pix_data_in_B = b_q;
    assign vid.per_img_red = a_q[23:16];
    assign vid.per_img_green = a_q[15:8];
    assign vid.per_img_blue = a_q[7:0];
    assign vid.target_x = cur_x;
    assign vid.frame_cnt = frame_cnt;
    assign vid.frame_done = done_q;
endmodule

// File: tb/tb_video_frame_source.sv
// tb_video_frame_source: slot-index reference model for a small raster, plus pacing checks on a divided-clock instance
module tb_video_frame_source;
    localparam int HD = 16, VD = 8, HB = 4, VB = 2, BW = 4, BH = 3, BY = 2, ST = 4;
    localparam int HT = HD + HB, VT = VD + VB, LAST = HT * VT - 1;
    logic clk = 1'b0, rst = 1'b1, run = 1'b0, rst2 = 1'b1, run2 = 1'b0;
    int checks = 0, errors = 0;
    int m_act = 0, m_s = 0, m_fc = 0;
    int n_clk = 0, n_hr = 0, n_vs = 0, href_p = 0, tx_cur = 0, tx_old = 0;
    int cyc_n = 0, last_c2 = -1, last_fd2 = -1, n_c2 = 0, h2_run = 0, c2_prev = 0;
    int seq [8] = '{0, 4, 8, 12, 8, 4, 0, 4};
    video_frame_source_if v1 ();
    video_frame_source_if v2 ();
    video_frame_source #(.IMG_HDISP(10'd16), .IMG_VDISP(10'd8), .H_BLANK(10'd4), .V_BLANK(10'd2),
        .PIX_DIV(4'd1), .BOX_W(10'd4), .BOX_H(10'd3), .BOX_Y(10'd2), .STEP(10'd4))
        u1 (.sys_clk(clk), .sys_rst(rst), .run(run), .vid(v1));
    video_frame_source #(.IMG_HDISP(10'd16), .IMG_VDISP(10'd8), .H_BLANK(10'd4), .V_BLANK(10'd2),
        .PIX_DIV(4'd3), .BOX_W(10'd4), .BOX_H(10'd3), .BOX_Y(10'd2), .STEP(10'd4))
        u2 (.sys_clk(clk), .sys_rst(rst2), .run(run2), .vid(v2));
    always #5 clk = ~clk;

    function automatic int pos(input int k);
        int x = 0;
        bit left = 0;
        for (int i = 0; i < k; i++)
            if (left) begin
                if (x < ST) begin left = 0; x += ST; end
                else x -= ST;
            end else begin
                if (x + ST + BW > HD) begin left = 1; x -= ST; end
                else x += ST;
            end
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic clr();
        n_clk = 0; n_hr = 0; n_vs = 0;
    endtask

    task automatic cyc();
        logic ev, eh, ed;
        logic [23:0] ea, eb;
        int h, v, x, p;
        ev = 0; eh = 0; ed = 0; ea = 0; eb = 0;
        if (rst) begin
            m_act = 0; m_s = 0; m_fc = 0;
        end else if (m_act != 0) begin
            h = m_s % HT; v = m_s / HT;
            x = pos(m_fc);
            p = m_fc == 0 ? 0 : pos(m_fc - 1);
            ev = v < VD;
            eh = ev && h < HD;
            ea = (eh && v >= BY && v < BY + BH && h >= x && h < x + BW) ? 24'hFFFFFF : 24'h0;
            eb = (eh && v >= BY && v < BY + BH && h >= p && h < p + BW) ? 24'hFFFFFF : 24'h0;
            ed = m_s == LAST;
            if (ed) begin m_s = 0; m_fc++; m_act = run; end
            else m_s++;
        end else m_act = run;
        @(posedge clk);
        @(negedge clk);
        chk("vsync", v1.per_frame_vsync, ev);
        chk("href", v1.per_frame_href, eh);
        chk("clken", v1.per_frame_clken, eh);
        chk("pix_A", v1.pix_data_in_A, ea);
        chk("pix_B", v1.pix_data_in_B, eb);
        chk("red", v1.per_img_red, ea[23:16]);
        chk("green", v1.per_img_green, ea[15:8]);
        chk("blue", v1.per_img_blue, ea[7:0]);
        chk("target_x", v1.target_x, pos(m_fc));
        chk("frame_cnt", v1.frame_cnt, m_fc & 16'hFFFF);
        chk("frame_done", v1.frame_done, ed);
        n_clk += v1.per_frame_clken;
        if (v1.per_frame_href && href_p == 0) n_hr++;
        n_vs += v1.per_frame_vsync;
        href_p = v1.per_frame_href;
        tx_old = tx_cur;
        tx_cur = v1.target_x;
        cyc_n++;
        if (v2.per_frame_clken) begin
            chk("clken2_width", c2_prev, 0);
            if (h2_run != 0 && last_c2 >= 0) chk("clken2_gap", cyc_n - last_c2, 3);
            last_c2 = cyc_n; h2_run = 1; n_c2++;
        end
        if (!v2.per_frame_href) h2_run = 0;
        if (v2.frame_done) begin
            if (last_fd2 >= 0) begin
                chk("period2", cyc_n - last_fd2, 600);
                chk("clken2_cnt", n_c2, 128);
            end
            last_fd2 = cyc_n; n_c2 = 0;
        end
        c2_prev = v2.per_frame_clken;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin cyc(); n++; end while (!v1.frame_done && n < 2000);
        chk("done_seen", v1.frame_done, 1);
    endtask

    initial begin
        int n, k;
        repeat (3) cyc();
        rst = 0; rst2 = 0;
        repeat (100) cyc();
        chk("idle_frame_cnt", v1.frame_cnt, 0);
        // first frame: latency from run, per-frame counts
        clr();
        run = 1; run2 = 1;
        wait_done(n);
        chk("first_done_clk", n, 201);
        chk("clken_cnt", n_clk, 128);
        chk("href_rises", n_hr, 8);
        chk("vsync_clks", n_vs, 160);
        clr();
        wait_done(n);
        chk("period", n, 200);
        chk("clken_cnt2", n_clk, 128);
        // stop mid-frame: the frame completes, then idle
        clr();
        k = 60 + int'($urandom_range(0, 19));
        repeat (k) cyc();
        run = 0;
        wait_done(n);
        chk("stop_clken", n_clk, 128);
        chk("stop_frame_cnt", v1.frame_cnt, 3);
        repeat (10) cyc();
        chk("stopped_vsync", v1.per_frame_vsync, 0);
        clr();
        run = 1;
        wait_done(n);
        chk("restart_done_clk", n, 201);
        chk("restart_clken", n_clk, 128);
        // reset mid-frame at line 5 of the next frame, run held high
        k = 100 + int'($urandom_range(0, 19));
        repeat (k) cyc();
        rst = 1;
        cyc();
        rst = 0;
        chk("rst_target_x", v1.target_x, 0);
        chk("rst_frame_cnt", v1.frame_cnt, 0);
        for (int f = 0; f < 8; f++) begin
            wait_done(n);
            chk("post_rst_period", n, f == 0 ? 201 : 200);
            chk("tx_seq", tx_old, seq[f]);
        end
        chk("final_frame_cnt", v1.frame_cnt, 8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
